// File: rtl/enc_bin2gray.sv
// Binary-to-Gray encoder: zero-latency combinational output plus a
// registered copy with valid qualifier and single-bit-step monitor.
module enc_bin2gray #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] gray_q,
  output logic             out_valid,
  output logic             step_one
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] gray_d;
  logic             out_valid_d;
  logic             out_valid_q;
  logic             step_one_d;
  logic             step_one_q;
  logic             hist_d;
  logic             hist_q;
  logic [WIDTH-1:0] diff;
  logic             one_hot;

  assign gray = bin ^ (bin >> 1);

  // Power-of-two test: nonzero with only one set bit
  assign diff    = gray ^ gray_q;
  assign one_hot = (diff != '0) && ((diff & (diff - ONE)) == '0);

  always_comb begin
    gray_d      = gray_q;
    out_valid_d = 1'b0;
    step_one_d  = 1'b0;
    hist_d      = hist_q;
    if (in_valid) begin
      gray_d      = gray;
      out_valid_d = 1'b1;
      step_one_d  = hist_q && one_hot;
      hist_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gray_q      <= '0;
      out_valid_q <= 1'b0;
      step_one_q  <= 1'b0;
      hist_q      <= 1'b0;
    end else begin
      gray_q      <= gray_d;
      out_valid_q <= out_valid_d;
      step_one_q  <= step_one_d;
      hist_q      <= hist_d;
    end
  end

  assign out_valid = out_valid_q;
  assign step_one  = step_one_q;

endmodule

// File: tb/tb_enc_bin2gray.sv
// Scoreboard bench for enc_bin2gray: random and directed stimulus
// against an arithmetic Gray/Hamming reference model.
module tb_enc_bin2gray;

  localparam int W = 10;
  localparam int N = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] bin;
  logic         in_valid;
  logic [W-1:0] gray;
  logic [W-1:0] gray_q;
  logic         out_valid;
  logic         step_one;

  int checks = 0;
  int failures = 0;

  logic [W:0] exp_q[$];
  int         m_prev;
  bit         m_hist;

  always #5 clk = ~clk;

  enc_bin2gray #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .bin(bin), .in_valid(in_valid),
    .gray(gray), .gray_q(gray_q), .out_valid(out_valid),
    .step_one(step_one)
  );

  function automatic int enc(int n);
    return n ^ (n / 2);
  endfunction

  function automatic int hdist(int a, int b);
    int x = a ^ b;
    int c = 0;
    for (int i = 0; i < W; i++) c += (x >> i) & 1;
    return c;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic cyc(int b, bit v, bit r);
    int g;
    bin = b[W-1:0];
    in_valid = v;
    rst = r;
    g = enc(b);
    if (r) begin
      m_hist = 0;
      m_prev = 0;
    end else if (v) begin
      exp_q.push_back({(m_hist && hdist(g, m_prev) == 1), g[W-1:0]});
      m_prev = g;
      m_hist = 1;
    end
    #1;
    check("gray_comb", int'(gray), g);
    @(posedge clk);
    #1;
    check("gray_q_model", int'(gray_q), m_prev);
  endtask

  always @(negedge clk) begin
    logic [W:0] e;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_out: out_valid=1 expected 0 @%0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_gray_q", int'(gray_q), int'(e[W-1:0]));
        check("sb_step_one", int'(step_one), int'(e[W]));
      end
    end else begin
      check("idle_step_one", int'(step_one), 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: timeout reached expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    m_hist = 0;
    m_prev = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    bin = '0;
    for (int i = 0; i < N; i++) begin
      bin = i[W-1:0];
      #1;
      check("sweep", int'(gray), i ^ (i >> 1));
    end
    bin = 10'h000; #1; check("spot0", int'(gray), 'h000);
    bin = 10'h001; #1; check("spot1", int'(gray), 'h001);
    bin = 10'h002; #1; check("spot2", int'(gray), 'h003);
    bin = 10'h003; #1; check("spot3", int'(gray), 'h002);
    bin = 10'h200; #1; check("msb", int'(gray), 'h300);
    bin = 10'h3FF; #1; check("all1", int'(gray), 'h200);
    bin = 10'h155; #1; check("alt", int'(gray), 'h1FF);

    cyc(0, 0, 1);
    cyc(0, 0, 1);
    check("rst_gray_q", int'(gray_q), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_step_one", int'(step_one), 0);

    cyc(5, 1, 0);
    check("first_gray_q", int'(gray_q), 'h007);
    check("first_valid", int'(out_valid), 1);
    check("first_step", int'(step_one), 0);
    cyc(6, 1, 0);
    check("step56_gq", int'(gray_q), 'h005);
    check("step56", int'(step_one), 1);
    cyc(5, 1, 0);
    cyc(7, 1, 0);
    check("step57_gq", int'(gray_q), 'h004);
    check("step57", int'(step_one), 0);
    cyc(1023, 1, 0);
    check("wrap_hi", int'(gray_q), 'h200);
    cyc(0, 1, 0);
    check("wrap_gq", int'(gray_q), 'h000);
    check("wrap_step", int'(step_one), 1);
    cyc(0, 1, 0);
    check("equal_step", int'(step_one), 0);

    for (int i = 0; i < 3; i++) begin
      cyc(37 + i, 0, 0);
      check("hold_gq", int'(gray_q), 'h000);
      check("hold_valid", int'(out_valid), 0);
    end

    cyc(2, 1, 0);
    cyc(10'h3FF, 1, 1);
    check("rst_gray", int'(gray), 'h200);
    check("rst_mid_gq", int'(gray_q), 0);
    cyc(1, 1, 0);
    check("post_rst_gq", int'(gray_q), 'h001);
    check("post_rst_step", int'(step_one), 0);

    b = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) != 0) b = (b + 1) % N;
      else b = int'($urandom_range(N - 1));
      cyc(b, $urandom_range(3) != 0, $urandom_range(99) == 0);
    end

    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
